ctrl_sequencer: RTL and testbench



---
 rtl/ctrl_sequencer.sv | 166 ++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// Microstep control sequencer: steps through the fetch/execute T-states and
// decodes the IR opcode into the 16-bit control word that drives the register bank.
module ctrl_sequencer #(
  parameter int unsigned NUM_STEPS = 5,  // legal range 5..8
  parameter bit          EARLY_END = 1'b1
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [3:0]  opcode,
  input  logic        flag_c,
  input  logic        flag_z,
  output logic [15:0] ctrl,
  output logic [2:0]  step,
  output logic        halted
);

  // Control word bit positions
  localparam int unsigned PcInc     = 0;
  localparam int unsigned PcOut     = 1;
  localparam int unsigned PcLoad    = 2;
  localparam int unsigned MarLoad   = 3;
  localparam int unsigned RamOut    = 4;
  localparam int unsigned RamLoad   = 5;
  localparam int unsigned IrLoad    = 6;
  localparam int unsigned IrOut     = 7;
  localparam int unsigned ALoad     = 8;
  localparam int unsigned AOut      = 9;
  localparam int unsigned BLoad     = 10;
  localparam int unsigned AluOut    = 11;
  localparam int unsigned AluSub    = 12;
  localparam int unsigned OutLoad   = 13;
  localparam int unsigned FlagsLoad = 14;
  localparam int unsigned Hlt       = 15;

  localparam logic [2:0] MaxStep = 3'(NUM_STEPS - 1);

  logic [2:0]  r_step;
  logic        r_halted;
  logic [2:0]  w_step_next;
  logic        w_halted_next;
  logic [15:0] w_ctrl;
  logic [2:0]  w_last_step;

  // Microcode decode: control word and last active step for the current opcode
  always_comb begin
    w_ctrl      = '0;
    w_last_step = 3'd1;
    unique case (opcode)
      4'd1: w_last_step = 3'd3;
      4'd2: w_last_step = 3'd4;
      4'd3: w_last_step = 3'd4;
      4'd4: w_last_step = 3'd3;
      4'd5, 4'd6, 4'd7, 4'd8, 4'd14, 4'd15: w_last_step = 3'd2;
      default: w_last_step = 3'd1;
    endcase

    if (CLR) begin
      w_ctrl = '0;
    end else if (r_halted) begin
      w_ctrl[Hlt] = 1'b1;
    end else begin
      unique case (r_step)
        3'd0: begin
          w_ctrl[PcOut]   = 1'b1;
          w_ctrl[MarLoad] = 1'b1;
        end
        3'd1: begin
          w_ctrl[RamOut] = 1'b1;
          w_ctrl[IrLoad] = 1'b1;
          w_ctrl[PcInc]  = 1'b1;
        end
        3'd2: begin
          unique case (opcode)
            4'd1, 4'd2, 4'd3, 4'd4: begin
              w_ctrl[IrOut]   = 1'b1;
              w_ctrl[MarLoad] = 1'b1;
            end
            4'd5: begin
              w_ctrl[IrOut] = 1'b1;
              w_ctrl[ALoad] = 1'b1;
            end
            4'd6: begin
              w_ctrl[IrOut]  = 1'b1;
              w_ctrl[PcLoad] = 1'b1;
            end
            4'd7: begin
              w_ctrl[IrOut]  = flag_c;
              w_ctrl[PcLoad] = flag_c;
            end
            4'd8: begin
              w_ctrl[IrOut]  = flag_z;
              w_ctrl[PcLoad] = flag_z;
            end
            4'd14: begin
              w_ctrl[AOut]    = 1'b1;
              w_ctrl[OutLoad] = 1'b1;
            end
            4'd15: w_ctrl[Hlt] = 1'b1;
            default: w_ctrl = '0;
          endcase
        end
        3'd3: begin
          unique case (opcode)
            4'd1: begin
              w_ctrl[RamOut] = 1'b1;
              w_ctrl[ALoad]  = 1'b1;
            end
            4'd2, 4'd3: begin
              w_ctrl[RamOut] = 1'b1;
              w_ctrl[BLoad]  = 1'b1;
            end
            4'd4: begin
              w_ctrl[AOut]    = 1'b1;
              w_ctrl[RamLoad] = 1'b1;
            end
            default: w_ctrl = '0;
          endcase
        end
        3'd4: begin
          if (opcode == 4'd2 || opcode == 4'd3) begin
            w_ctrl[AluOut]    = 1'b1;
            w_ctrl[ALoad]     = 1'b1;
            w_ctrl[FlagsLoad] = 1'b1;
            w_ctrl[AluSub]    = (opcode == 4'd3);
          end
        end
        default: w_ctrl = '0;
      endcase
    end
  end

  // Next-state: step advance, early end and halt freeze
  always_comb begin
    w_step_next   = r_step;
    w_halted_next = r_halted;
    if (r_halted) begin
      w_step_next = r_step;
    end else if (opcode == 4'd15 && r_step == 3'd2) begin
      // Halt freezes the step counter at T2
      w_halted_next = 1'b1;
      w_step_next   = 3'd2;
    end else if (r_step >= MaxStep) begin
      w_step_next = 3'd0;
    end else if (EARLY_END && r_step >= w_last_step) begin
      w_step_next = 3'd0;
    end else begin
      w_step_next = r_step + 3'd1;
    end
  end

  // State register with synchronous clear
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_step   <= 3'd0;
      r_halted <= 1'b0;
    end else begin
      r_step   <= w_step_next;
      r_halted <= w_halted_next;
    end
  end

  assign ctrl   = w_ctrl;
  assign step   = r_step;
  assign halted = r_halted;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed scoreboard bench for ctrl_sequencer (EARLY_END=1 and EARLY_END=0 instances).
module tb_ctrl_sequencer;

  typedef struct packed {
    logic        sel;   // 0: early-end instance, 1: full-run instance
    logic [15:0] c;
    logic [2:0]  s;
    logic        h;
  } exp_t;

  logic        clk;
  logic        clr;
  logic [3:0]  opcode;
  logic        flag_c;
  logic        flag_z;
  logic [15:0] ctrl_e, ctrl_f;
  logic [2:0]  step_e, step_f;
  logic        halted_e, halted_f;

  int checks;
  int failures;
  exp_t q[$];

  ctrl_sequencer #(.NUM_STEPS(5), .EARLY_END(1'b1)) dut (
    .CLK(clk), .CLR(clr), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
    .ctrl(ctrl_e), .step(step_e), .halted(halted_e)
  );

  ctrl_sequencer #(.NUM_STEPS(5), .EARLY_END(1'b0)) dut_full (
    .CLK(clk), .CLR(clr), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
    .ctrl(ctrl_f), .step(step_f), .halted(halted_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int out_count(input logic [15:0] c);
    return int'(c[1]) + int'(c[4]) + int'(c[7]) + int'(c[9]) + int'(c[11]);
  endfunction

  // Pop expectations and compare away from the active edge
  always @(negedge clk) begin
    exp_t e;
    logic [15:0] ac;
    logic [2:0]  as_;
    logic        ah;
    checks++;
    assert (out_count(ctrl_e) <= 1 && out_count(ctrl_f) <= 1) else begin
      failures++;
      $error("FAIL bus_contention ctrl_e=%h ctrl_f=%h required at most one out bit",
             ctrl_e, ctrl_f);
    end
    if (q.size() > 0) begin
      e   = q.pop_front();
      ac  = e.sel ? ctrl_f : ctrl_e;
      as_ = e.sel ? step_f : step_e;
      ah  = e.sel ? halted_f : halted_e;
      checks++;
      assert (ac === e.c) else begin
        failures++;
        $error("FAIL ctrl[%0d] t=%0t got=%h exp=%h", e.sel, $time, ac, e.c);
      end
      checks++;
      assert (as_ === e.s) else begin
        failures++;
        $error("FAIL step[%0d] t=%0t got=%0d exp=%0d", e.sel, $time, as_, e.s);
      end
      checks++;
      assert (ah === e.h) else begin
        failures++;
        $error("FAIL halted[%0d] t=%0t got=%b exp=%b", e.sel, $time, ah, e.h);
      end
    end
  end

  task automatic cyc(input logic sel, input logic [15:0] c, input logic [2:0] s,
                     input logic h);
    exp_t e;
    e.sel = sel; e.c = c; e.s = s; e.h = h;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch();
    cyc(1'b0, 16'h000A, 3'd0, 1'b0);
    cyc(1'b0, 16'h0051, 3'd1, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clr      = 1'b1;
    opcode   = 4'd3;
    flag_c   = 1'b0;
    flag_z   = 1'b0;
    @(posedge clk);
    #1;
    // Reset held for a second edge, ctrl forced to zero
    cyc(1'b0, 16'h0000, 3'd0, 1'b0);
    clr = 1'b0;

    // LDA
    opcode = 4'd1;
    fetch();
    cyc(1'b0, 16'h0088, 3'd2, 1'b0);
    cyc(1'b0, 16'h0110, 3'd3, 1'b0);
    // SUB
    opcode = 4'd3;
    fetch();
    cyc(1'b0, 16'h0088, 3'd2, 1'b0);
    cyc(1'b0, 16'h0410, 3'd3, 1'b0);
    cyc(1'b0, 16'h5900, 3'd4, 1'b0);
    // ADD
    opcode = 4'd2;
    fetch();
    cyc(1'b0, 16'h0088, 3'd2, 1'b0);
    cyc(1'b0, 16'h0410, 3'd3, 1'b0);
    cyc(1'b0, 16'h4900, 3'd4, 1'b0);
    // JC taken / not taken
    opcode = 4'd7;
    flag_c = 1'b1;
    fetch();
    cyc(1'b0, 16'h0084, 3'd2, 1'b0);
    flag_c = 1'b0;
    fetch();
    cyc(1'b0, 16'h0000, 3'd2, 1'b0);
    // JZ taken / not taken, with carry set to expose wrong gating
    opcode = 4'd8;
    flag_z = 1'b1;
    fetch();
    cyc(1'b0, 16'h0084, 3'd2, 1'b0);
    flag_z = 1'b0;
    flag_c = 1'b1;
    fetch();
    cyc(1'b0, 16'h0000, 3'd2, 1'b0);
    flag_c = 1'b0;
    // STA
    opcode = 4'd4;
    fetch();
    cyc(1'b0, 16'h0088, 3'd2, 1'b0);
    cyc(1'b0, 16'h0220, 3'd3, 1'b0);
    // LDI, JMP, OUT
    opcode = 4'd5;
    fetch();
    cyc(1'b0, 16'h0180, 3'd2, 1'b0);
    opcode = 4'd6;
    fetch();
    cyc(1'b0, 16'h0084, 3'd2, 1'b0);
    opcode = 4'd14;
    fetch();
    cyc(1'b0, 16'h2200, 3'd2, 1'b0);
    // NOP and undefined opcode end at T1
    opcode = 4'd0;
    fetch();
    opcode = 4'd11;
    fetch();
    // CLR during ADD T3: no a_load/b_load pulse, back to T0
    opcode = 4'd2;
    fetch();
    cyc(1'b0, 16'h0088, 3'd2, 1'b0);
    clr = 1'b1;
    cyc(1'b0, 16'h0000, 3'd3, 1'b0);
    clr = 1'b0;
    fetch();
    cyc(1'b0, 16'h0088, 3'd2, 1'b0);
    cyc(1'b0, 16'h0410, 3'd3, 1'b0);
    cyc(1'b0, 16'h4900, 3'd4, 1'b0);
    // HLT, then hold through opcode changes
    opcode = 4'd15;
    fetch();
    cyc(1'b0, 16'h8000, 3'd2, 1'b0);
    for (int i = 0; i < 12; i++) begin
      opcode = 4'(i);
      flag_c = i[0];
      flag_z = i[1];
      cyc(1'b0, 16'h8000, 3'd2, 1'b1);
    end
    clr = 1'b1;
    cyc(1'b0, 16'h0000, 3'd2, 1'b1);
    clr    = 1'b0;
    opcode = 4'd0;
    flag_c = 1'b0;
    flag_z = 1'b0;
    // Full-run instance: NOP runs all five steps and wraps
    cyc(1'b1, 16'h000A, 3'd0, 1'b0);
    cyc(1'b1, 16'h0051, 3'd1, 1'b0);
    cyc(1'b1, 16'h0000, 3'd2, 1'b0);
    cyc(1'b1, 16'h0000, 3'd3, 1'b0);
    cyc(1'b1, 16'h0000, 3'd4, 1'b0);
    cyc(1'b1, 16'h000A, 3'd0, 1'b0);
    cyc(1'b1, 16'h0051, 3'd1, 1'b0);
    // Full-run LDI: T3/T4 silent, still wraps
    opcode = 4'd5;
    cyc(1'b1, 16'h0180, 3'd2, 1'b0);
    cyc(1'b1, 16'h0000, 3'd3, 1'b0);
    cyc(1'b1, 16'h0000, 3'd4, 1'b0);
    cyc(1'b1, 16'h000A, 3'd0, 1'b0);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    checks++;
    assert (q.size() == 0) else begin
      failures++;
      $error("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
